// File: rtl/linebuf_scanout.sv
// linebuf_scanout: read side of the double-buffered line buffer.
// Generates 640x480@60 style timing, fetches palette indices through the
// line buffer read port and shows each entry as a 2x2 pixel block. Owns
// linesel and tells the renderer which buffer line to fill next.
module linebuf_scanout #(
  parameter int H_TOTAL      = 800,
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int V_TOTAL      = 525,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       linesel,
  output logic [8:0] idx2,
  input  logic [6:0] rddata2,
  output logic       render_start,
  output logic [7:0] render_line,
  output logic [6:0] pix_data,
  output logic       pix_de,
  output logic       vga_hsync_n,
  output logic       vga_vsync_n
);

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]  HS_START = 10'(H_SYNC_START);
  localparam logic [9:0]  HS_END   = 10'(H_SYNC_END);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START = 10'(V_SYNC_START);
  localparam logic [9:0]  VS_END   = 10'(V_SYNC_END);
  localparam logic [10:0] V_TOT    = 11'(V_TOTAL);
  localparam logic [8:0]  RL_LIMIT = 9'(V_ACTIVE / 2);

  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic        line_end;
  logic [9:0]  nv;
  logic [10:0] nv_plus2;
  logic [9:0]  rl_wrap;
  logic [8:0]  rl;
  logic        hact;
  logic        vact;
  logic        hsync_n;
  logic        vsync_n;

  // Stage-1 pipeline: timing flags aligned with the RAM read latency.
  logic        de_d1;
  logic        hsync_n_d1;
  logic        vsync_n_d1;

  // Decode current counters: active area, syncs, read index, next line.
  // NOTE: every always_comb output gets a value on every path (here all are
  // plain assignments), so no latches are inferred.
  always_comb begin
    line_end = (hcnt == H_LAST);
    nv       = (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
    // nv + 2 is below 2*V_TOTAL, so one conditional subtract is the modulo.
    nv_plus2 = {1'b0, nv} + 11'd2;
    rl_wrap  = (nv_plus2 >= V_TOT) ? 10'(nv_plus2 - V_TOT) : nv_plus2[9:0];
    rl       = rl_wrap[9:1];
    hact     = (hcnt < H_ACT);
    vact     = (vcnt < V_ACT);
    hsync_n  = !((hcnt >= HS_START) && (hcnt < HS_END));
    vsync_n  = !((vcnt >= VS_START) && (vcnt < VS_END));
    idx2     = hact ? hcnt[9:1] : '0;
  end

  // Horizontal and vertical position counters, both wrapping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= nv;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  // Buffer half swap on every even next line, with a render request for the
  // buffer line that will be needed two lines from now.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      linesel      <= 1'b0;
      render_start <= 1'b0;
      render_line  <= '0;
    end else begin
      render_start <= 1'b0;
      if (line_end && !nv[0]) begin
        linesel <= ~linesel;
        if (rl < RL_LIMIT) begin
          render_start <= 1'b1;
          render_line  <= rl[7:0];
        end
      end
    end
  end

  // Stage 1: hold timing flags while the line buffer read is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_d1      <= 1'b0;
      hsync_n_d1 <= 1'b1;
      vsync_n_d1 <= 1'b1;
    end else begin
      de_d1      <= hact && vact;
      hsync_n_d1 <= hsync_n;
      vsync_n_d1 <= vsync_n;
    end
  end

  // Stage 2: registered outputs; pixel data blanked outside the active area.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_data    <= '0;
      pix_de      <= 1'b0;
      vga_hsync_n <= 1'b1;
      vga_vsync_n <= 1'b1;
    end else begin
      pix_data    <= de_d1 ? rddata2 : '0;
      pix_de      <= de_d1;
      vga_hsync_n <= hsync_n_d1;
      vga_vsync_n <= vsync_n_d1;
    end
  end

endmodule

// File: tb/tb_linebuf_scanout.sv
// Self-checking bench for linebuf_scanout using reduced timing so several
// full frames fit in a short run. Expected values come from closed-form
// arithmetic on the number of clocks since reset release.
module tb_linebuf_scanout;

  localparam int H   = 50;
  localparam int HA  = 32;
  localparam int HS0 = 36;
  localparam int HS1 = 42;
  localparam int V   = 25;
  localparam int VA  = 16;
  localparam int VS0 = 18;
  localparam int VS1 = 20;
  localparam int FRAME = H * V;

  typedef struct {
    logic [6:0] data;
    logic       de;
    logic       hs_n;
    logic       vs_n;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       linesel;
  logic [8:0] idx2;
  logic [6:0] rddata2 = '0;
  logic       render_start;
  logic [7:0] render_line;
  logic [6:0] pix_data;
  logic       pix_de;
  logic       vga_hsync_n;
  logic       vga_vsync_n;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n = 0;
  int   last_rl = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  logic [6:0] mem [512];

  linebuf_scanout #(
    .H_TOTAL(H), .H_ACTIVE(HA), .H_SYNC_START(HS0), .H_SYNC_END(HS1),
    .V_TOTAL(V), .V_ACTIVE(VA), .V_SYNC_START(VS0), .V_SYNC_END(VS1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .linesel(linesel),
    .idx2(idx2),
    .rddata2(rddata2),
    .render_start(render_start),
    .render_line(render_line),
    .pix_data(pix_data),
    .pix_de(pix_de),
    .vga_hsync_n(vga_hsync_n),
    .vga_vsync_n(vga_vsync_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (n=%0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  // Reference: display outputs for the counter position reached after c clocks.
  function automatic exp_t exp_out(input int c);
    exp_t e;
    int h, v;
    h = c % H;
    v = (c / H) % V;
    e.de   = (h < HA) && (v < VA);
    e.data = e.de ? mem[h / 2] : 7'd0;
    e.hs_n = !((h >= HS0) && (h < HS1));
    e.vs_n = !((v >= VS0) && (v < VS1));
    return e;
  endfunction

  // linesel flips once per even line entered; a frame enters (V+1)/2 of them.
  function automatic int exp_linesel(input int c);
    int lines, f, v;
    lines = c / H;
    f = lines / V;
    v = lines % V;
    return (f * ((V + 1) / 2) + v / 2) % 2;
  endfunction

  function automatic int exp_idx(input int c);
    int h;
    h = c % H;
    return (h < HA) ? h / 2 : 0;
  endfunction

  // Render request visible at clock c: just entered an even line whose
  // buffer line two lines ahead is within the visible buffer.
  function automatic bit exp_pulse(input int c, output int rl);
    int v;
    v  = (c / H) % V;
    rl = ((v + 2) % V) / 2;
    return (c > 0) && (c % H == 0) && (v % 2 == 0) && (rl < VA / 2);
  endfunction

  // Monitor: compare each presented output set with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow: got empty queue expected entry (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("pix_de", pix_de, e.de);
          check("pix_data", pix_data, e.data);
          check("hsync_n", vga_hsync_n, e.hs_n);
          check("vsync_n", vga_vsync_n, e.vs_n);
        end
      end
    end
  end

  task automatic apply_reset(input int len);
    exp_t idle;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_pix_data", pix_data, 7'd0);
    check("rst_pix_de", pix_de, 1'b0);
    check("rst_hsync_n", vga_hsync_n, 1'b1);
    check("rst_vsync_n", vga_vsync_n, 1'b1);
    check("rst_linesel", linesel, 1'b0);
    check("rst_render_start", render_start, 1'b0);
    check("rst_render_line", render_line, 8'd0);
    check("rst_idx2", idx2, 9'd0);
    sb.delete();
    for (int i = 0; i < 512; i++) mem[i] = 7'($urandom);
    repeat (len) @(posedge clk);
    #2;
    reset_n = 1'b1;
    n = 0;
    last_rl = 0;
    // Two output slots elapse before the first counter position shows.
    idle.data = '0;
    idle.de   = 1'b0;
    idle.hs_n = 1'b1;
    idle.vs_n = 1'b1;
    sb.push_back(idle);
    sb.push_back(idle);
    mon_en = 1'b1;
  endtask

  task automatic run_cycles(input int k);
    logic [8:0] saved;
    int rl;
    bit pulse;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      sb.push_back(exp_out(n));
      pulse = exp_pulse(n, rl);
      if (pulse) last_rl = rl;
      check("idx2", idx2, exp_idx(n));
      check("linesel", linesel, exp_linesel(n));
      check("render_start", render_start, pulse);
      check("render_line", render_line, last_rl);
      saved = idx2;
      @(posedge clk);
      #1;
      rddata2 = mem[saved];
      n++;
    end
  endtask

  initial begin
    #2;
    apply_reset(5);
    run_cycles(3 * FRAME + 100);
    // Restart, then reset again inside vsync/hsync with linesel set.
    @(posedge clk);
    #1;
    apply_reset(3);
    run_cycles(VS0 * H + HS0 + 1);
    check("pre_reset_linesel", linesel, exp_linesel(n));
    apply_reset(5);
    run_cycles(2 * FRAME + 50);
    for (int r = 0; r < 3; r++) begin
      apply_reset($urandom_range(1, 6));
      run_cycles($urandom_range(100, 2 * FRAME));
    end
    @(negedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
